mul_share_ctrl: RTL and testbench

MUL_SHARE_CTRL -- requirements
Module: mul_share_ctrl

---
 rtl/clm_typedefs.sv | 31 +++
 rtl/rr_arbiter.sv | 33 +++
 rtl/mul_share_ctrl.sv | 141 ++++++++++++++
 tb/tb_mul_share_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/clm_typedefs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | clm_typedefs                                                               |
// | Shared defaults, FSM state encoding and helpers for mul_share_ctrl.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package clm_typedefs;

  localparam int unsigned c_n_req   = 4;
  localparam int unsigned c_mul_w   = 16;
  localparam int unsigned c_timeout = 63;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Index of the highest set bit; callers only pass one-hot or zero vectors.
  function automatic int unsigned onehot_idx(input logic [31:0] v);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arbiter                                                                 |
// | Combinational round-robin picker: first active request at or after ptr.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic             vld
);

  logic [PTR_W-1:0] w_idx;

  always_comb begin
    gnt   = '0;
    vld   = 1'b0;
    w_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_idx = PTR_W'((32'(ptr) + i) % N_REQ);
      if (!vld && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        vld        = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_share_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mul_share_ctrl                                                             |
// | Round-robin sharing of one multi-cycle multiplier among N_REQ requesters. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mul_share_ctrl
  import clm_typedefs::*;
#(
  parameter int unsigned N_REQ   = c_n_req,
  parameter int unsigned MUL_W   = c_mul_w,
  parameter int unsigned TIMEOUT = c_timeout
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ-1:0][MUL_W-1:0] p1_i,
  input  logic [N_REQ-1:0][MUL_W-1:0] p2_i,
  output logic [N_REQ-1:0]            gnt_o,
  output logic [MUL_W-1:0]            res_o,
  output logic [N_REQ-1:0]            res_vld_o,
  output logic                        err_o,
  output logic                        busy_o,
  output logic                        mul_drdy_o,
  output logic [MUL_W-1:0]            mul_p1_o,
  output logic [MUL_W-1:0]            mul_p2_o,
  input  logic                        mul_drdy_i,
  input  logic [MUL_W-1:0]            mul_out_i
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t             r_state;
  state_t             w_next;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_idx;
  logic [N_REQ-1:0]   r_win;
  logic [MUL_W-1:0]   r_p1;
  logic [MUL_W-1:0]   r_p2;
  logic [MUL_W-1:0]   r_res;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_timeout;

  logic [N_REQ-1:0]   w_arb_gnt;
  logic               w_arb_vld;
  logic [PTR_W-1:0]   w_arb_idx;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic               w_cnt_last;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req (req_i),
    .ptr (r_ptr),
    .gnt (w_arb_gnt),
    .vld (w_arb_vld)
  );

  assign w_arb_idx  = PTR_W'(onehot_idx(32'(w_arb_gnt)));
  assign w_ptr_nxt  = (r_idx == PTR_W'(N_REQ - 1)) ? '0 : r_idx + 1'b1;
  assign w_cnt_last = (r_cnt == CNT_W'(TIMEOUT - 1));

  assign busy_o   = (r_state != ST_IDLE);
  assign res_o    = r_res;
  assign mul_p1_o = r_p1;
  assign mul_p2_o = r_p2;

  always_comb begin
    w_next     = r_state;
    gnt_o      = '0;
    res_vld_o  = '0;
    err_o      = 1'b0;
    mul_drdy_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_vld) w_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        gnt_o      = r_win;
        mul_drdy_o = 1'b1;
        w_next     = ST_WAIT;
      end
      ST_WAIT: begin
        if (mul_drdy_i || w_cnt_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        // A timed-out job reuses DONE but reports err_o instead of a result.
        if (r_timeout) err_o = 1'b1;
        else           res_vld_o = r_win;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_win     <= '0;
      r_p1      <= '0;
      r_p2      <= '0;
      r_res     <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_arb_vld) begin
            r_win <= w_arb_gnt;
            r_idx <= w_arb_idx;
            r_p1  <= p1_i[w_arb_idx];
            r_p2  <= p2_i[w_arb_idx];
          end
        end
        ST_ISSUE: begin
          r_cnt     <= '0;
          r_timeout <= 1'b0;
        end
        ST_WAIT: begin
          if (mul_drdy_i) begin
            r_res <= mul_out_i;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_cnt_last) r_timeout <= 1'b1;
          end
        end
        ST_DONE: begin
          r_ptr <= w_ptr_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_share_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mul_share_ctrl                                                          |
// | Directed self-checking bench for mul_share_ctrl.                           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mul_share_ctrl;

  localparam int N = 4;
  localparam int W = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N-1:0]        req_i = '0;
  logic [N-1:0][W-1:0] p1_i = '0;
  logic [N-1:0][W-1:0] p2_i = '0;
  logic [N-1:0]        gnt_o;
  logic [W-1:0]        res_o;
  logic [N-1:0]        res_vld_o;
  logic                err_o;
  logic                busy_o;
  logic                mul_drdy_o;
  logic [W-1:0]        mul_p1_o;
  logic [W-1:0]        mul_p2_o;
  logic                mul_drdy_i = 1'b0;
  logic [W-1:0]        mul_out_i = '0;

  int n_total = 0;
  int n_bad   = 0;

  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];
  logic [W-1:0] hold;

  mul_share_ctrl #(.N_REQ(N), .MUL_W(W), .TIMEOUT(63)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .p1_i       (p1_i),
    .p2_i       (p2_i),
    .gnt_o      (gnt_o),
    .res_o      (res_o),
    .res_vld_o  (res_vld_o),
    .err_o      (err_o),
    .busy_o     (busy_o),
    .mul_drdy_o (mul_drdy_o),
    .mul_p1_o   (mul_p1_o),
    .mul_p2_o   (mul_p2_o),
    .mul_drdy_i (mul_drdy_i),
    .mul_out_i  (mul_out_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Entered at the negedge of the IDLE cycle in which the request is sampled.
  task automatic run_txn(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int k, input logic [N-1:0] clr);
    logic [W-1:0] prod;
    prod = a * b;
    tick();
    chk("issue_gnt",  32'(gnt_o), 32'(1) << idx);
    chk("issue_strb", 32'(mul_drdy_o), 32'd1);
    chk("issue_p1",   32'(mul_p1_o), 32'(a));
    chk("issue_p2",   32'(mul_p2_o), 32'(b));
    chk("issue_busy", 32'(busy_o), 32'd1);
    req_i = req_i & ~clr;
    for (int c = 2; c < k; c++) begin
      tick();
      chk("wait_vld", 32'(res_vld_o), 32'd0);
      chk("wait_p1",  32'(mul_p1_o), 32'(a));
    end
    tick();
    chk("wait_strb", 32'(mul_drdy_o), 32'd0);
    chk("wait_p2",   32'(mul_p2_o), 32'(b));
    mul_drdy_i = 1'b1;
    mul_out_i  = prod;
    tick();
    mul_drdy_i = 1'b0;
    mul_out_i  = '0;
    chk("done_vld", 32'(res_vld_o), 32'(1) << idx);
    chk("done_res", 32'(res_o), 32'(prod));
    chk("done_gnt", 32'(gnt_o), 32'd0);
    chk("done_err", 32'(err_o), 32'd0);
    tick();
    chk("idle_busy", 32'(busy_o), 32'd0);
    chk("idle_vld",  32'(res_vld_o), 32'd0);
    chk("idle_res",  32'(res_o), 32'(prod));
  endtask

  initial begin
    op_a[0] = 16'h1234; op_b[0] = 16'h0003;
    op_a[1] = 16'h0f0f; op_b[1] = 16'h1010;
    op_a[2] = 16'hffff; op_b[2] = 16'hffff;
    op_a[3] = 16'h8001; op_b[3] = 16'h7ffe;

    // Reset state
    repeat (2) tick();
    chk("rst_gnt",  32'(gnt_o), 32'd0);
    chk("rst_vld",  32'(res_vld_o), 32'd0);
    chk("rst_err",  32'(err_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_strb", 32'(mul_drdy_o), 32'd0);
    chk("rst_p1",   32'(mul_p1_o), 32'd0);
    chk("rst_res",  32'(res_o), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single requester, multiplier done five cycles after issue
    p1_i[0] = 16'hc23f;
    p2_i[0] = 16'hb2f4;
    req_i   = 4'b0001;
    run_txn(0, 16'hc23f, 16'hb2f4, 6, 4'b0001);

    for (int i = 0; i < N; i++) begin
      p1_i[i] = op_a[i];
      p2_i[i] = op_b[i];
    end

    // ptr=1 -> serve 1 to move ptr to 2, then 0011 must give 0 then 1
    req_i = 4'b0010;
    run_txn(1, op_a[1], op_b[1], 3, 4'b0010);
    req_i = 4'b0011;
    run_txn(0, op_a[0], op_b[0], 2, 4'b0001);
    run_txn(1, op_a[1], op_b[1], 2, 4'b0010);

    // Timeout: requester 2, multiplier never answers
    hold  = op_a[1] * op_b[1];
    req_i = 4'b0100;
    tick();
    chk("to_gnt", 32'(gnt_o), 32'h4);
    req_i = 4'b0000;
    for (int c = 2; c <= 64; c++) begin
      tick();
      chk("to_wait_err",  32'(err_o), 32'd0);
      chk("to_wait_busy", 32'(busy_o), 32'd1);
    end
    tick();
    chk("to_err",  32'(err_o), 32'd1);
    chk("to_vld",  32'(res_vld_o), 32'd0);
    tick();
    chk("to_busy_after", 32'(busy_o), 32'd0);
    chk("to_err_after",  32'(err_o), 32'd0);
    chk("to_res_hold",   32'(res_o), 32'(hold));

    // ptr=3 -> serve 3 so the full-load sweep starts at 0
    req_i = 4'b1000;
    run_txn(3, op_a[3], op_b[3], 2, 4'b1000);

    // All four requesting continuously: 0,1,2,3,0
    req_i = 4'b1111;
    run_txn(0, op_a[0], op_b[0], 2, 4'b0000);
    run_txn(1, op_a[1], op_b[1], 3, 4'b0000);
    run_txn(2, op_a[2], op_b[2], 2, 4'b0000);
    run_txn(3, op_a[3], op_b[3], 4, 4'b0000);
    run_txn(0, op_a[0], op_b[0], 2, 4'b1111);

    // Spurious multiplier done while idle
    hold       = op_a[0] * op_b[0];
    mul_drdy_i = 1'b1;
    mul_out_i  = 16'hdead;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("spur_busy", 32'(busy_o), 32'd0);
      chk("spur_vld",  32'(res_vld_o), 32'd0);
      chk("spur_gnt",  32'(gnt_o), 32'd0);
      chk("spur_res",  32'(res_o), 32'(hold));
    end
    mul_drdy_i = 1'b0;
    mul_out_i  = '0;
    tick();

    // Reset while waiting on the multiplier
    req_i = 4'b0001;
    tick();
    chk("rw_gnt", 32'(gnt_o), 32'h1);
    req_i = 4'b0000;
    repeat (2) tick();
    chk("rw_busy", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rw_rst_busy", 32'(busy_o), 32'd0);
    chk("rw_rst_res",  32'(res_o), 32'd0);
    chk("rw_rst_p1",   32'(mul_p1_o), 32'd0);
    chk("rw_rst_p2",   32'(mul_p2_o), 32'd0);
    chk("rw_rst_vld",  32'(res_vld_o), 32'd0);
    chk("rw_rst_err",  32'(err_o), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rw_post_vld", 32'(res_vld_o), 32'd0);
    chk("rw_post_err", 32'(err_o), 32'd0);
    // Pointer must restart at 0: 1001 grants 0 first, then 3 alone
    req_i = 4'b1001;
    run_txn(0, op_a[0], op_b[0], 2, 4'b0001);
    run_txn(3, op_a[3], op_b[3], 3, 4'b1000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
